// File: rtl/branch_resolve_ctrl_pkg.sv
// branch_resolve_ctrl_pkg: shared FSM states, comparator op codes and operand-need helper.
package branch_resolve_ctrl_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, EVAL, REDIR} state_t;
  localparam logic [2:0] OP_BEQ  = 3'b110;
  localparam logic [2:0] OP_BNE  = 3'b001;
  localparam logic [2:0] OP_BLEZ = 3'b010;
  localparam logic [2:0] OP_BGTZ = 3'b011;
  localparam logic [2:0] OP_BLTZ = 3'b100;
  localparam logic [2:0] OP_BGEZ = 3'b101;
  function automatic logic needs_rt(input logic [2:0] op);
    return op == OP_BEQ || op == OP_BNE;
  endfunction
endpackage

// File: rtl/branch_resolve_ctrl_profile_cnt.sv
// branch_profile_cnt: wrapping counters of resolved and taken branches.
module branch_profile_cnt (
  input  logic        clk,
  input  logic        reset,
  input  logic        br_done,
  input  logic        taken,
  output logic [31:0] taken_cnt,
  output logic [31:0] resolved_cnt
);
  always_ff @(posedge clk) begin
    if (reset) begin
      taken_cnt    <= '0;
      resolved_cnt <= '0;
    end else begin
      if (br_done) resolved_cnt <= resolved_cnt + 32'd1;
      if (taken) taken_cnt <= taken_cnt + 32'd1;
    end
  end
endmodule

// File: rtl/branch_resolve_ctrl.sv
// branch_resolve_ctrl: ID-stage branch sequencer (operand wait, compare, PC redirect).
// Profile counters are built only when BRANCH_PROFILE_EN is defined.
module branch_resolve_ctrl
  import branch_resolve_ctrl_pkg::*;
#(
  parameter int          WAIT_W   = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        br_valid,
  input  logic [2:0]  br_op,
  input  logic [31:0] br_target,
  input  logic        rs_ready,
  input  logic        rt_ready,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic [2:0]  cmp_op,
  output logic [31:0] cmp_a,
  output logic [31:0] cmp_b,
  input  logic        cmp_br,
  input  logic        pc_ready,
  output logic        stall,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        br_done,
  output logic        err_deadlock,
  output logic [31:0] taken_cnt,
  output logic [31:0] resolved_cnt
);
  state_t state, state_n;
  logic [WAIT_W-1:0] wait_cnt, wait_nxt;
  logic [31:0] target;
  logic [2:0] op_sel;
  logic ops_ok, accept, capture, timeout;
  assign op_sel   = state == IDLE ? br_op : cmp_op;
  assign ops_ok   = rs_ready & (rt_ready | !needs_rt(op_sel));
  assign accept   = state == IDLE & br_valid & !flush;
  assign capture  = !flush & ops_ok & (accept | state == WAIT);
  assign wait_nxt = wait_cnt + {{(WAIT_W-1){1'b0}}, 1'b1};
  assign timeout  = !flush & state == WAIT & !ops_ok & wait_nxt == '1;
  assign redirect_valid = state == REDIR;
  always_comb begin
    state_n = state;
    stall   = 1'b0;
    br_done = 1'b0;
    case (state)
      IDLE: begin
        stall   = br_valid & !flush;
        state_n = br_valid ? (ops_ok ? EVAL : WAIT) : IDLE;
      end
      WAIT: begin
        stall   = 1'b1;
        state_n = ops_ok ? EVAL : (timeout ? IDLE : WAIT);
      end
      EVAL: begin
        stall   = cmp_br;
        br_done = !cmp_br;
        state_n = cmp_br ? REDIR : IDLE;
      end
      default: begin
        stall   = !pc_ready;
        br_done = pc_ready;
        state_n = pc_ready ? IDLE : REDIR;
      end
    endcase
    if (flush) begin
      state_n = IDLE;
      br_done = 1'b0;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      cmp_op       <= '0;
      cmp_a        <= '0;
      cmp_b        <= '0;
      target       <= '0;
      wait_cnt     <= '0;
      redirect_pc  <= RESET_PC;
      err_deadlock <= 1'b0;
    end else begin
      state <= state_n;
      if (accept) begin
        cmp_op   <= br_op;
        target   <= br_target;
        wait_cnt <= '0;
      end
      if (state == WAIT) wait_cnt <= wait_nxt;
      if (capture) begin
        cmp_a <= rs_val;
        cmp_b <= needs_rt(op_sel) ? rt_val : '0;
      end
      if (timeout) err_deadlock <= 1'b1;
      if (!flush & state == EVAL & cmp_br) redirect_pc <= target;
    end
  end
`ifdef BRANCH_PROFILE_EN
  branch_profile_cnt u_prof (
    .clk          (clk),
    .reset        (reset),
    .br_done      (br_done),
    .taken        (br_done & state == REDIR),
    .taken_cnt    (taken_cnt),
    .resolved_cnt (resolved_cnt)
  );
`else
  assign taken_cnt    = '0;
  assign resolved_cnt = '0;
`endif
endmodule
